// File: rtl/msrv_32_branch_ctrl.sv
// Branch/jump resolution for the EX stage. Decides whether a branch or jump is taken,
// redirects fetch to the target and flushes the front end for a fixed number of cycles.
module msrv_32_branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ex_valid_in,
  input  logic [4:0]  opcode_6_to_2_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm_in,
  input  logic        fetch_ready_in,
  output logic        redirect_valid_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out,
  output logic        busy_out,
  output logic        misaligned_exc_out,
  output logic [31:0] misaligned_addr_out
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_d, addr_d;
  logic        exc_d;
  logic        taken;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  always_comb begin
    taken    = 1'b0;
    jalr_sum = rs1_in + imm_in;
    target   = pc_in + imm_in;
    case (opcode_6_to_2_in)
      5'b11000: begin
        case (funct3_in)
          3'b000:  taken = (rs1_in == rs2_in);
          3'b001:  taken = (rs1_in != rs2_in);
          3'b100:  taken = ($signed(rs1_in) <  $signed(rs2_in));
          3'b101:  taken = ($signed(rs1_in) >= $signed(rs2_in));
          3'b110:  taken = (rs1_in <  rs2_in);
          3'b111:  taken = (rs1_in >= rs2_in);
          default: taken = 1'b0;
        endcase
      end
      5'b11011: taken = 1'b1;
      5'b11001: begin
        taken  = 1'b1;
        target = {jalr_sum[31:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = redirect_pc_out;
    addr_d  = misaligned_addr_out;
    exc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_in && taken) begin
          if (target[1]) begin
            exc_d  = 1'b1;
            addr_d = target;
          end else begin
            pc_d    = target;
            state_d = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (fetch_ready_in) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        // counter of 1 is the last flush cycle; 0 only guards against a stray entry
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next-state values so they align with the state register.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      redirect_valid_out  <= 1'b0;
      redirect_pc_out     <= '0;
      flush_out           <= 1'b0;
      busy_out            <= 1'b0;
      misaligned_exc_out  <= 1'b0;
      misaligned_addr_out <= '0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      redirect_valid_out  <= (state_d == REDIRECT);
      redirect_pc_out     <= pc_d;
      flush_out           <= (state_d != IDLE);
      busy_out            <= (state_d != IDLE);
      misaligned_exc_out  <= exc_d;
      misaligned_addr_out <= addr_d;
    end
  end

endmodule

// File: tb/tb_msrv_32_branch_ctrl.sv
// Bench for msrv_32_branch_ctrl: directed scenarios plus random traffic, compared
// every cycle against a remaining-cycles model of the redirect/flush behaviour.
module tb_msrv_32_branch_ctrl;

  localparam int unsigned FC = 2;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic        mis_exc;
  logic [31:0] mis_addr;

  int checks   = 0;
  int failures = 0;
  bit run      = 0;

  msrv_32_branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .ex_valid_in          (ex_valid),
    .opcode_6_to_2_in     (opcode),
    .funct3_in            (funct3),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .pc_in                (pc),
    .imm_in               (imm),
    .fetch_ready_in       (fetch_ready),
    .redirect_valid_out   (redirect_valid),
    .redirect_pc_out      (redirect_pc),
    .flush_out            (flush),
    .busy_out             (busy),
    .misaligned_exc_out   (mis_exc),
    .misaligned_addr_out  (mis_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_taken(input logic [4:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    if (op == OP_JAL || op == OP_JALR) return 1'b1;
    if (op != OP_BR) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] p, input logic [31:0] i);
    if (op == OP_JALR) return (a + i) & 32'hFFFF_FFFE;
    return p + i;
  endfunction

  // Model: a pending-redirect flag plus a count of flush cycles still owed.
  bit          m_rv;
  int          m_left;
  bit          m_exc;
  logic [31:0] m_pc, m_addr, t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rv = 0; m_left = 0; m_exc = 0; m_pc = '0; m_addr = '0;
    end else begin
      m_exc = 0;
      if (m_rv) begin
        if (fetch_ready) begin
          m_rv   = 0;
          m_left = int'(FC);
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (ex_valid && m_taken(opcode, funct3, rs1, rs2)) begin
        t = m_target(opcode, rs1, pc, imm);
        if (t[1]) begin
          m_exc  = 1;
          m_addr = t;
        end else begin
          m_rv = 1;
          m_pc = t;
        end
      end
    end
  end

  wire m_busy = m_rv || (m_left > 0);

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("cmp_redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("cmp_redirect_pc",    redirect_pc,         m_pc);
      chk("cmp_flush",          32'(flush),          32'(m_busy));
      chk("cmp_busy",           32'(busy),           32'(m_busy));
      chk("cmp_misaligned_exc", 32'(mis_exc),        32'(m_exc));
      chk("cmp_misaligned_addr", mis_addr,           m_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input bit rdy);
    ex_valid = v; opcode = op; funct3 = f3;
    rs1 = a; rs2 = b; pc = p; imm = i; fetch_ready = rdy;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 40) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 32'(m_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, '0, '0, '0, '0, '0, '0, 0);
    #1 rst = 1'b1;
    #1;
    chk("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_pc",    redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1;

    // BEQ taken: one redirect cycle, then FC flush-only cycles
    drive(1, OP_BR, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1);
    tick();
    chk("beq_rv", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush1", 32'(flush), 32'd1);
    ex_valid = 0;
    tick();
    chk("beq_rv_off", 32'(redirect_valid), 32'd0);
    chk("beq_flush2", 32'(flush), 32'd1);
    tick();
    chk("beq_flush3", 32'(flush), 32'd1);
    tick();
    chk("beq_flush_end", 32'(flush), 32'd0);
    chk("beq_busy_end",  32'(busy),  32'd0);

    // Signed vs unsigned compares
    drive(1, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1);
    tick();
    chk("blt_taken", 32'(redirect_valid), 32'd1);
    chk("blt_pc", redirect_pc, 32'h240);
    ex_valid = 0;
    wait_idle();
    drive(1, OP_BR, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1);
    tick();
    chk("bltu_not_taken", 32'(redirect_valid), 32'd0);
    chk("bltu_busy", 32'(busy), 32'd0);
    funct3 = 3'b111;
    tick();
    chk("bgeu_taken", 32'(redirect_valid), 32'd1);
    ex_valid = 0;
    wait_idle();

    // JALR misaligned, then aligned with bit 0 cleared
    drive(1, OP_JALR, 3'b000, 32'h1003, 32'h0, 32'h300, 32'h0, 1);
    tick();
    chk("jalr_exc", 32'(mis_exc), 32'd1);
    chk("jalr_addr", mis_addr, 32'h1002);
    chk("jalr_no_redirect", 32'(redirect_valid), 32'd0);
    ex_valid = 0;
    tick();
    chk("jalr_exc_pulse", 32'(mis_exc), 32'd0);
    chk("jalr_addr_held", mis_addr, 32'h1002);
    drive(1, OP_JALR, 3'b000, 32'h1001, 32'h0, 32'h300, 32'h0, 1);
    tick();
    chk("jalr_redirect", 32'(redirect_valid), 32'd1);
    chk("jalr_pc", redirect_pc, 32'h1000);
    ex_valid = 0;
    wait_idle();

    // Backpressure: redirect holds while a new jump is presented and ignored
    drive(1, OP_BR, 3'b001, 32'h1, 32'h2, 32'h400, 32'h80, 0);
    tick();
    drive(1, OP_JAL, 3'b000, 32'h0, 32'h0, 32'h800, 32'h10, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(redirect_valid), 32'd1);
      chk("bp_pc", redirect_pc, 32'h480);
      tick();
    end
    drive(0, '0, '0, '0, '0, '0, '0, 1);
    tick();
    chk("bp_to_flush_rv", 32'(redirect_valid), 32'd0);
    chk("bp_to_flush_fl", 32'(flush), 32'd1);
    wait_idle();

    // Wrap-around target, then asynchronous reset during FLUSH
    drive(1, OP_JAL, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1);
    tick();
    chk("wrap_pc", redirect_pc, 32'h10);
    ex_valid = 0;
    tick();
    chk("wrap_in_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_rv",    32'(redirect_valid), 32'd0);
    chk("arst_pc",    redirect_pc, 32'd0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_exc",   32'(mis_exc), 32'd0);
    chk("arst_addr",  mis_addr, 32'd0);
    #1 rst = 1'b0;
    drive(1, OP_BR, 3'b000, 32'h7, 32'h7, 32'h40, 32'h8, 1);
    tick();
    chk("post_reset_accept", 32'(redirect_valid), 32'd1);
    chk("post_reset_pc", redirect_pc, 32'h48);
    ex_valid = 0;
    wait_idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0]  op;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       op = OP_BR;
        1:       op = OP_JAL;
        2:       op = OP_JALR;
        default: op = 5'($urandom);
      endcase
      a = $urandom;
      drive(bit'($urandom_range(0, 3) != 0), op, 3'($urandom), a,
            ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
            $urandom, $urandom, bit'($urandom_range(0, 1)));
      tick();
    end
    drive(0, '0, '0, '0, '0, '0, '0, 1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
